// File: rtl/score_pkg.sv
// Shared definitions for the score renderer: glyph geometry, BCD digit type,
// the award FSM state encoding and the packed-BCD helper functions.
package score_pkg;

  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int MAX_DIGITS = 6;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADD  = 1'b1
  } score_state_t;

  // All-9s value for the lowest `digits` digits of a maximum-width BCD word.
  function automatic logic [4*MAX_DIGITS-1:0] bcd_max(input int digits);
    logic [4*MAX_DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) v[4*i +: 4] = 4'd9;
    end
    return v;
  endfunction

  // Packed-BCD +1 over the lowest `digits` digits with decimal ripple carry.
  // When every digit is already 9 the input is returned unchanged, so the
  // counter saturates instead of wrapping to zero.
  function automatic logic [4*MAX_DIGITS-1:0] bcd_inc(
    input logic [4*MAX_DIGITS-1:0] v,
    input int                      digits
  );
    logic [4*MAX_DIGITS-1:0] r;
    logic                    carry;
    bcd_digit_t              d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry && (i < digits)) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return carry ? v : r;
  endfunction

endpackage

// File: rtl/number_rom.sv
// Digit glyph ROM: 8x16 bitmaps for '0'..'9'. Address is digit*16 + row,
// row 0 at the top, bit 7 the leftmost pixel. Addresses 160..255 read 0.
module number_rom (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  logic [127:0] glyph;
  logic [6:0]   lsb;

  // Select the 16-row bitmap of the digit, then the byte for the row.
  always_comb begin
    case (addr[7:4])
      4'd0:    glyph = 128'h0000_7cc6_c6ce_def6_e6c6_c67c_0000_0000;
      4'd1:    glyph = 128'h0000_1838_7818_1818_1818_187e_0000_0000;
      4'd2:    glyph = 128'h0000_7cc6_060c_1830_60c0_c6fe_0000_0000;
      4'd3:    glyph = 128'h0000_7cc6_0606_3c06_0606_c67c_0000_0000;
      4'd4:    glyph = 128'h0000_0c1c_3c6c_ccfe_0c0c_0c1e_0000_0000;
      4'd5:    glyph = 128'h0000_fec0_c0c0_fc06_0606_c67c_0000_0000;
      4'd6:    glyph = 128'h0000_3860_c0c0_fcc6_c6c6_c67c_0000_0000;
      4'd7:    glyph = 128'h0000_fec6_0606_0c18_3030_3030_0000_0000;
      4'd8:    glyph = 128'h0000_7cc6_c6c6_7cc6_c6c6_c67c_0000_0000;
      4'd9:    glyph = 128'h0000_7cc6_c6c6_7e06_0606_0c78_0000_0000;
      default: glyph = '0;
    endcase
    // Row r lives at bits [(15-r)*8 +: 8]; (15-r)*8 == {~r, 3'b000}.
    lsb  = {~addr[3:0], 3'b000};
    data = glyph[lsb +: 8];
  end

endmodule

// File: rtl/score_renderer.sv
// Scoreboard controller: packed-BCD score counter fed by a valid/ready award
// interface, a per-frame display snapshot, and a two-stage pipeline that
// turns raster coordinates into glyph pixels through the digit ROM.
module score_renderer
  import score_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int X0     = 16,
  parameter int Y0     = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                clear,
  input  logic                add_valid,
  input  logic [6:0]          add_points,
  output logic                add_ready,
  input  logic                frame_start,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  output logic                score_pixel,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic                saturated
);

  localparam int W = 4 * DIGITS;

  localparam logic [9:0]   X_LO      = 10'(X0);
  localparam logic [9:0]   X_HI      = 10'(X0 + GLYPH_W * DIGITS);
  localparam logic [9:0]   Y_LO      = 10'(Y0);
  localparam logic [9:0]   Y_HI      = 10'(Y0 + GLYPH_H);
  localparam logic [W-1:0] SCORE_MAX = W'(bcd_max(DIGITS));

  score_state_t            state;
  logic [6:0]              remaining;
  logic [W-1:0]            score;
  logic [W-1:0]            score_next;
  logic [W-1:0]            disp;
  logic [4*MAX_DIGITS-1:0] score_wide;

  assign score_wide = (4*MAX_DIGITS)'(score);
  assign score_next = W'(bcd_inc(score_wide, DIGITS));
  assign add_ready  = (state == IDLE);
  assign saturated  = (score == SCORE_MAX);
  assign score_bcd  = score;

  // Award FSM and score counter; clear wins over everything, dropping any
  // pending points and any request presented in the same cycle.
  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      score     <= '0;
    end else if (clear) begin
      state     <= IDLE;
      remaining <= '0;
      score     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (add_valid && (add_points != 7'd0)) begin
            remaining <= add_points;
            state     <= ADD;
          end
        end
        ADD: begin
          score     <= score_next;
          remaining <= remaining - 7'd1;
          if (remaining == 7'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame snapshot so a frame never shows a score that is still counting.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         disp <= '0;
    else if (frame_start) disp <= score;
  end

  logic [9:0] dx;
  logic [3:0] row;
  logic       in_box;
  bcd_digit_t digit;

  assign dx     = DrawX - X_LO;
  assign row    = 4'(DrawY - Y_LO);
  assign in_box = (DrawX >= X_LO) && (DrawX < X_HI) &&
                  (DrawY >= Y_LO) && (DrawY < Y_HI);

  // Pick the displayed digit under the pixel; index 0 is the leftmost digit.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dx[9:3] == 7'(i)) digit = disp[4*(DIGITS-1-i) +: 4];
    end
  end

  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [2:0] col_q;
  logic       vld_q;

  // Stage 1: register ROM address, glyph column and the in-box flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      col_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      rom_addr <= {digit, row};
      col_q    <= dx[2:0];
      vld_q    <= in_box;
    end
  end

  number_rom u_number_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  // Stage 2: pick the glyph bit, blanked outside the score box.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) score_pixel <= 1'b0;
    else          score_pixel <= vld_q & rom_data[3'd7 - col_q];
  end

endmodule

// File: tb/tb_score_renderer.sv
// Directed self-checking bench for score_renderer (default parameters).
module tb_score_renderer;

  localparam int DIGITS = 4;
  localparam int X0     = 16;
  localparam int Y0     = 8;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        clear;
  logic        add_valid;
  logic [6:0]  add_points;
  logic        add_ready;
  logic        frame_start;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        score_pixel;
  logic [15:0] score_bcd;
  logic        saturated;

  int errors = 0;
  int checks = 0;
  int busy;

  always #5 Clk = ~Clk;

  score_renderer #(.DIGITS(DIGITS), .X0(X0), .Y0(Y0)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .clear       (clear),
    .add_valid   (add_valid),
    .add_points  (add_points),
    .add_ready   (add_ready),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .score_pixel (score_pixel),
    .score_bcd   (score_bcd),
    .saturated   (saturated)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one award request and count the cycles add_ready stays low.
  task automatic do_add(input logic [6:0] pts, output int n_busy);
    add_valid  = 1'b1;
    add_points = pts;
    tick;
    add_valid  = 1'b0;
    add_points = '0;
    n_busy     = 0;
    while (add_ready !== 1'b1 && n_busy < 200) begin
      n_busy++;
      tick;
    end
  endtask

  // Reference bitmaps for the digits the raster checks draw.
  function automatic logic [7:0] glyph_row(input logic [3:0] d, input int r);
    logic [127:0] g;
    logic [6:0]   lsb;
    case (d)
      4'd0:    g = 128'h0000_7cc6_c6ce_def6_e6c6_c67c_0000_0000;
      4'd9:    g = 128'h0000_7cc6_c6c6_7e06_0606_0c78_0000_0000;
      default: g = '0;
    endcase
    lsb = 7'((15 - r) * 8);
    return g[lsb +: 8];
  endfunction

  function automatic logic exp_pixel(input int x, input int y, input logic [15:0] shown);
    int         dx;
    int         idx;
    logic [3:0] d;
    logic [7:0] bits;
    if (x < X0 || x >= X0 + 8*DIGITS || y < Y0 || y >= Y0 + 16) return 1'b0;
    dx   = x - X0;
    idx  = dx / 8;
    d    = shown[4*(DIGITS-1-idx) +: 4];
    bits = glyph_row(d, y - Y0);
    return bits[7 - (dx % 8)];
  endfunction

  // Stream one pixel per cycle and compare each output two cycles later.
  task automatic raster(input int xa, input int xb, input int ya, input int yb,
                        input logic [15:0] shown, input string tag);
    logic e1;
    logic e2;
    int   n;
    e1 = 1'b0;
    e2 = 1'b0;
    n  = 0;
    for (int y = ya; y <= yb; y++) begin
      for (int x = xa; x <= xb; x++) begin
        if (n >= 2) check(tag, score_pixel, e2);
        DrawX = 10'(x);
        DrawY = 10'(y);
        e2    = e1;
        e1    = exp_pixel(x, y, shown);
        tick;
        n++;
      end
    end
    check(tag, score_pixel, e2);
    DrawX = '0;
    DrawY = '0;
    tick;
    check(tag, score_pixel, e1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset_n     = 1'b0;
    clear       = 1'b0;
    add_valid   = 1'b0;
    add_points  = '0;
    frame_start = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    repeat (3) tick;

    // Reset state
    check("rst_score", score_bcd, 16'h0000);
    check("rst_ready", add_ready, 1'b1);
    check("rst_pixel", score_pixel, 1'b0);
    check("rst_sat", saturated, 1'b0);
    Reset_n = 1'b1;
    tick;
    check("post_rst_ready", add_ready, 1'b1);

    // Idle frame: "0000" inside the box, blank one pixel beyond every edge
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    raster(X0 - 1, X0 + 8*DIGITS, Y0 - 1, Y0 + 16, 16'h0000, "reset_frame");

    // Zero-point request is consumed without going busy
    do_add(7'd0, busy);
    check("add0_busy", busy, 0);
    check("add0_score", score_bcd, 16'h0000);

    // Add with carry, back-to-back requests
    do_add(7'd7, busy);
    check("add7_busy", busy, 7);
    check("add7_score", score_bcd, 16'h0007);
    do_add(7'd5, busy);
    check("add5_busy", busy, 5);
    check("add5_score", score_bcd, 16'h0012);
    do_add(7'd87, busy);
    check("add87_busy", busy, 87);
    check("add87_score", score_bcd, 16'h0099);
    do_add(7'd1, busy);
    check("carry2_busy", busy, 1);
    check("carry2_score", score_bcd, 16'h0100);

    // Saturation: preload to 9990 (78 x 127 + 84), then add 20
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("clr_score", score_bcd, 16'h0000);
    for (int i = 0; i < 78; i++) do_add(7'd127, busy);
    do_add(7'd84, busy);
    check("pre_sat_score", score_bcd, 16'h9990);
    check("pre_sat_flag", saturated, 1'b0);
    do_add(7'd20, busy);
    check("sat_busy", busy, 20);
    check("sat_score", score_bcd, 16'h9999);
    check("sat_flag", saturated, 1'b1);
    do_add(7'd1, busy);
    check("sat_hold", score_bcd, 16'h9999);

    // Clear in the 3rd busy cycle of an add of 100, with add_valid also high
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("clr2_sat", saturated, 1'b0);
    add_valid  = 1'b1;
    add_points = 7'd100;
    tick;
    add_valid  = 1'b0;
    check("clr_busy1_ready", add_ready, 1'b0);
    tick;
    tick;
    check("clr_busy3_score", score_bcd, 16'h0002);
    clear      = 1'b1;
    add_valid  = 1'b1;
    add_points = 7'd5;
    tick;
    check("clr_mid_score", score_bcd, 16'h0000);
    check("clr_mid_ready", add_ready, 1'b1);
    clear      = 1'b0;
    add_valid  = 1'b0;
    add_points = '0;
    tick;
    check("clr_drop_score", score_bcd, 16'h0000);
    check("clr_drop_ready", add_ready, 1'b1);

    // Asynchronous reset mid-add loses the pending points
    add_valid  = 1'b1;
    add_points = 7'd30;
    tick;
    add_valid  = 1'b0;
    add_points = '0;
    repeat (4) tick;
    check("rstmid_pre", score_bcd, 16'h0004);
    Reset_n = 1'b0;
    #1;
    check("rstmid_score", score_bcd, 16'h0000);
    check("rstmid_ready", add_ready, 1'b1);
    tick;
    Reset_n = 1'b1;
    tick;
    tick;
    check("rstmid_after", score_bcd, 16'h0000);
    check("rstmid_after_ready", add_ready, 1'b1);

    // Snapshot isolation: latch 0009 while an add of 50 is running
    add_valid  = 1'b1;
    add_points = 7'd50;
    tick;
    add_valid  = 1'b0;
    add_points = '0;
    repeat (9) tick;
    check("snap_pre", score_bcd, 16'h0009);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check("snap_live", score_bcd, 16'h0010);
    raster(X0, X0 + 8*DIGITS - 1, Y0, Y0 + 15, 16'h0009, "snapshot_frame");
    check("snap_final", score_bcd, 16'h0050);
    check("snap_ready", add_ready, 1'b1);

    // Pixel alignment on score 0042
    clear = 1'b1;
    tick;
    clear = 1'b0;
    do_add(7'd42, busy);
    check("s42_score", score_bcd, 16'h0042);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    DrawX = '0;
    DrawY = '0;
    tick;
    tick;
    check("align_outside", score_pixel, 1'b0);
    DrawX = 10'(X0 + 24 + 1);
    DrawY = 10'(Y0 + 2);
    tick;
    check("align_early", score_pixel, 1'b0);
    tick;
    check("align_two_r2c1", score_pixel, 1'b1);
    DrawX = 10'(X0 + 8*DIGITS);
    tick;
    tick;
    check("align_right_edge", score_pixel, 1'b0);
    DrawX = 10'(X0 + 16);
    DrawY = 10'(Y0 + 7);
    tick;
    tick;
    check("align_four_r7c0", score_pixel, 1'b1);
    DrawX = 10'(X0 + 30);
    DrawY = 10'(Y0 + 11);
    tick;
    tick;
    check("align_two_r11c6", score_pixel, 1'b1);
    DrawX = 10'(X0 + 31);
    tick;
    tick;
    check("align_two_r11c7", score_pixel, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
